seq_player: RTL and testbench

- Parametrised successor to the fixed 4-bit sequence tables.
- Holds NUM_SEQ selectable LED sequences of up to 2^ADDR_W steps, generated from a closed-form pattern rule.
- PLAY mode: steps through the selected sequence with timed on/off phases on saida.
- CHECK mode: compares player guesses step by step against the same sequence and reports pass or fail. Sits between the game controller FSM and the LED and button logic.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_rom.sv | 26 ++
 rtl/seq_player.sv | 159 +++++++++++++++
 tb/tb_seq_player.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player: state encoding, mode values,
// and default parameter values used by the top and its pattern generator.
package seq_pkg;

  // Controller states; encoding is fixed so external debug taps stay stable.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHOW    = 3'd1,
    GAP     = 3'd2,
    WAIT_IN = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic MODE_PLAY  = 1'b0;
  localparam logic MODE_CHECK = 1'b1;

  localparam int DEF_DATA_W    = 4;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_NUM_SEQ   = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_ON_TICKS  = 3;
  localparam int DEF_OFF_TICKS = 2;

endpackage

// File: rtl/seq_rom.sv
// Closed-form sequence table: pattern(s,k) = 1 << ((s + k*(2s+1)) mod DATA_W).
// Purely combinational; the working width leaves headroom so nothing
// overflows before the modulo is taken.
module seq_rom #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 2
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  localparam int AW = ADDR_W + SEL_W + 2;

  logic [AW-1:0] s_ext;
  logic [AW-1:0] k_ext;
  logic [AW-1:0] idx;

  assign s_ext   = AW'(sel);
  assign k_ext   = AW'(addr);
  // Step k of sequence s lands on LED index s + k*(2s+1), folded onto the LEDs.
  assign idx     = (s_ext + k_ext * ((s_ext << 1) + AW'(1))) % AW'(DATA_W);
  assign pattern = DATA_W'(1) << idx;

endmodule

// File: rtl/seq_player.sv
// Sequence player: PLAY shows a selected LED sequence with timed on/off
// phases; CHECK compares player guesses step by step and reports pass/fail.
// All outputs are registered; start is honoured only while idle.
module seq_player
  import seq_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_SEQ   = DEF_NUM_SEQ,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int ON_TICKS  = DEF_ON_TICKS,
  parameter int OFF_TICKS = DEF_OFF_TICKS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [SEL_W-1:0]  seq_sel,
  input  logic [ADDR_W:0]   length,
  input  logic              guess_valid,
  input  logic [DATA_W-1:0] guess,
  output logic [DATA_W-1:0] saida,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic              match
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMAX   = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TICK_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t              state;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W:0]     len_q;
  logic [TICK_W-1:0]   tick;

  logic [SEL_W:0]      sel_mod;
  logic [SEL_W-1:0]    sel_wrap;
  logic [ADDR_W:0]     len_clamp;
  logic [SEL_W-1:0]    rom_sel;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_pat;
  logic                last;

  // Out-of-range selectors fold back onto the implemented sequences.
  assign sel_mod   = {1'b0, seq_sel} % (SEL_W + 1)'(NUM_SEQ);
  assign sel_wrap  = sel_mod[SEL_W-1:0];
  assign len_clamp = (length > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH) : length;

  // While idle the table looks ahead at step 0 of the requested sequence so
  // the first pattern can be registered on the start edge; at the end of a
  // gap it looks ahead to the next step for the same reason.
  assign rom_sel  = (state == IDLE) ? sel_wrap : sel_q;
  assign rom_addr = (state == GAP) ? address + ADDR_W'(1) : address;

  assign last = ({1'b0, address} == len_q - (ADDR_W + 1)'(1));

  seq_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_rom (
    .sel     (rom_sel),
    .addr    (rom_addr),
    .pattern (rom_pat)
  );

  // Controller FSM with all outputs registered; done/match pulse on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      len_q   <= '0;
      tick    <= '0;
      saida   <= '0;
      address <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      match   <= 1'b0;
    end else begin
      done  <= 1'b0;
      match <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sel_q   <= sel_wrap;
            len_q   <= len_clamp;
            address <= '0;
            busy    <= 1'b1;
            saida   <= '0;
            if (len_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
              match <= 1'b1;
            end else if (mode == MODE_CHECK) begin
              state <= WAIT_IN;
            end else begin
              state <= SHOW;
              saida <= rom_pat;
              tick  <= TICK_W'(ON_TICKS - 1);
            end
          end
        end
        SHOW: begin
          if (tick == '0) begin
            state <= GAP;
            saida <= '0;
            tick  <= TICK_W'(OFF_TICKS - 1);
          end else begin
            tick <= tick - TICK_W'(1);
          end
        end
        GAP: begin
          if (tick == '0) begin
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
              match <= 1'b1;
            end else begin
              state   <= SHOW;
              address <= address + ADDR_W'(1);
              saida   <= rom_pat;
              tick    <= TICK_W'(ON_TICKS - 1);
            end
          end else begin
            tick <= tick - TICK_W'(1);
          end
        end
        WAIT_IN: begin
          saida <= '0;
          if (guess_valid) begin
            if (guess != rom_pat) begin
              state <= DONE;
              done  <= 1'b1;
              match <= 1'b0;
            end else if (last) begin
              state <= DONE;
              done  <= 1'b1;
              match <= 1'b1;
            end else begin
              address <= address + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          address <= '0;
          busy    <= 1'b0;
          saida   <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: stimulus pushes expected per-cycle outputs,
// a monitor pops and compares on every busy/done cycle.
// Reference behaviour is computed from the pattern rule with plain arithmetic.
module tb_seq_player;

  localparam int DW  = 4;
  localparam int AW  = 4;
  localparam int NS  = 4;
  localparam int SW  = 3;
  localparam int ONT = 3;
  localparam int OFT = 2;
  localparam int DEP = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [SW-1:0] seq_sel;
  logic [AW:0]   length;
  logic          guess_valid;
  logic [DW-1:0] guess;
  logic [DW-1:0] saida;
  logic [AW-1:0] address;
  logic          busy;
  logic          done;
  logic          match;

  typedef struct packed {
    logic [3:0] saida;
    logic [3:0] addr;
    logic       busy;
    logic       done;
    logic       match;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_player #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_SEQ(NS), .SEL_W(SW),
    .ON_TICKS(ONT), .OFF_TICKS(OFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .seq_sel(seq_sel),
    .length(length), .guess_valid(guess_valid), .guess(guess), .saida(saida),
    .address(address), .busy(busy), .done(done), .match(match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pat(int s, int k);
    logic [3:0] r;
    int i;
    i = (s + k * (2 * s + 1)) % DW;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic exp_t rec(logic [3:0] sd, int a, bit b, bit d, bit m);
    exp_t e;
    e.saida = sd;
    e.addr  = 4'(a);
    e.busy  = b;
    e.done  = d;
    e.match = m;
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] got, logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT reports activity, consume one expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (busy || done)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output busy=%0b done=%0b required=idle", busy, done);
        end else begin
          e = sb.pop_front();
          chk("saida",   8'(saida),   8'(e.saida));
          chk("address", 8'(address), 8'(e.addr));
          chk("busy",    8'(busy),    8'(e.busy));
          chk("done",    8'(done),    8'(e.done));
          chk("match",   8'(match),   8'(e.match));
        end
      end
    end
  end

  task automatic do_start(bit md, int sel, int len);
    @(posedge clk);
    #1;
    start   = 1'b1;
    mode    = md;
    seq_sel = SW'(sel);
    length  = (AW + 1)'(len);
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain remaining=%0d required=0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk({name, "_idle_busy"}, 8'(busy), 8'd0);
    chk({name, "_idle_address"}, 8'(address), 8'd0);
  endtask

  task automatic push_play(int sel, int len);
    int s;
    int n;
    s = sel % NS;
    n = (len > DEP) ? DEP : len;
    if (n == 0) begin
      sb.push_back(rec(4'h0, 0, 1, 1, 1));
    end else begin
      for (int k = 0; k < n; k++) begin
        for (int t = 0; t < ONT; t++) sb.push_back(rec(pat(s, k), k, 1, 0, 0));
        for (int t = 0; t < OFT; t++) sb.push_back(rec(4'h0, k, 1, 0, 0));
      end
      sb.push_back(rec(4'h0, n - 1, 1, 1, 1));
    end
  endtask

  task automatic run_play(int sel, int len);
    push_play(sel, len);
    do_start(1'b0, sel, len);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("play");
  endtask

  // errstep < 0 means every guess is correct; stray_start injects a start in WAIT_IN.
  task automatic run_check(int sel, int len, int errstep, bit stray_start);
    int s;
    int n;
    int idle;
    bit fin;
    logic [3:0] p;
    s = sel % NS;
    n = (len > DEP) ? DEP : len;
    do_start(1'b1, sel, len);
    if (n == 0) begin
      sb.push_back(rec(4'h0, 0, 1, 1, 1));
      @(posedge clk);
      #1;
      start = 1'b0;
    end else begin
      fin = 1'b0;
      for (int k = 0; k < n && !fin; k++) begin
        idle = $urandom_range(0, 2);
        if (stray_start && k == 0 && idle == 0) idle = 1;
        for (int i = 0; i < idle; i++) begin
          @(posedge clk);
          #1;
          guess_valid = 1'b0;
          start = (stray_start && k == 0 && i == 0);
          mode = 1'b0;
          seq_sel = 3'd3;
          length = 5'd5;
          sb.push_back(rec(4'h0, k, 1, 0, 0));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        p = pat(s, k);
        guess_valid = 1'b1;
        guess = (k == errstep) ? {p[2:0], p[3]} : p;
        sb.push_back(rec(4'h0, k, 1, 0, 0));
        if (k == errstep) begin
          sb.push_back(rec(4'h0, k, 1, 1, 0));
          fin = 1'b1;
        end else if (k == n - 1) begin
          sb.push_back(rec(4'h0, k, 1, 1, 1));
          fin = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      guess_valid = 1'b0;
    end
    drain("check");
  endtask

  initial begin
    int dseen;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    seq_sel = '0;
    length = '0;
    guess_valid = 1'b0;
    guess = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_saida", 8'(saida), 8'd0);
    chk("rst_address", 8'(address), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_match", 8'(match), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the feature list.
    run_play(0, 3);
    run_play(1, 4);
    run_check(2, 2, -1, 1'b1);
    run_check(2, 3, 1, 1'b0);
    run_play(0, 0);
    run_check(3, 0, -1, 1'b0);
    run_play(2, 20);
    run_play(5, 4);
    run_check(5, 4, -1, 1'b0);
    run_check(1, 20, -1, 1'b0);

    // Asynchronous reset in the middle of SHOW: outputs clear without a clock edge.
    push_play(0, 3);
    do_start(1'b0, 0, 3);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_saida", 8'(saida), 8'd0);
    chk("arst_address", 8'(address), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_done", 8'(done), 8'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dseen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("arst_no_done", 8'(dseen), 8'd0);

    // Randomized transactions.
    for (int t = 0; t < 14; t++) begin
      int sel;
      int len;
      int es;
      sel = $urandom_range(0, 7);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : $urandom_range(1, 6);
      if ($urandom_range(0, 1) == 0) begin
        run_play(sel, len);
      end else begin
        es = -1;
        if (len > 0 && $urandom_range(0, 1) == 1) es = $urandom_range(0, ((len > DEP) ? DEP : len) - 1);
        run_check(sel, len, es, $urandom_range(0, 1) == 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout reached required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
